// File: rtl/mmio_gpio_out_pkg.sv
// Shared register map, address decode and byte-merge helpers for mmio_gpio_out.
package mmio_gpio_out_pkg;

  localparam int unsigned WINDOW_BYTES = 64;

  localparam logic [5:0] OFF_DATA0  = 6'h00;
  localparam logic [5:0] OFF_MODE   = 6'h20;
  localparam logic [5:0] OFF_PERIOD = 6'h24;
  localparam logic [5:0] OFF_STATUS = 6'h28;

  typedef enum logic [2:0] {
    RegNone,
    RegData,
    RegMode,
    RegPeriod,
    RegStatus
  } regSel_t;

  // Channel index of a DATA register offset.
  function automatic logic [2:0] dataIndex(input logic [5:0] off);
    logic [5:0] rel;
    rel = off - OFF_DATA0;
    return rel[4:2];
  endfunction

  // Classify a window offset; DATA slots beyond the configured channels decode as RegNone.
  function automatic regSel_t decodeOffset(input logic [5:0] off, input int unsigned channels);
    logic [5:0] word;
    word = {off[5:2], 2'b00};
    if (word < OFF_MODE) begin
      if (32'(dataIndex(word)) < channels) return RegData;
      return RegNone;
    end
    case (word)
      OFF_MODE:   return RegMode;
      OFF_PERIOD: return RegPeriod;
      OFF_STATUS: return RegStatus;
      default:    return RegNone;
    endcase
  endfunction

  // Replace the strobed bytes of oldWord with the matching bytes of newWord.
  function automatic logic [31:0] mergeBytes(input logic [31:0] oldWord, input logic [31:0] newWord,
                                             input logic [3:0] strb);
    logic [31:0] res;
    res = oldWord;
    for (int unsigned b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = newWord[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/mmio_gpio_out_blink_timer.sv
// Half-period blink timer: free-running counter plus phase flip-flop.
module blink_timer #(
  parameter int unsigned pPeriodWidth = 24
) (
  input  logic                    iwClk,
  input  logic                    iwnRst,
  input  logic [pPeriodWidth-1:0] iwPeriod,
  input  logic                    iwClear,
  output logic                    owPhase
);

  logic [pPeriodWidth-1:0] count;
  logic                    phaseReg;

  // Count to PERIOD-1 then wrap and toggle; a PERIOD write restarts the count without touching phase.
  always_ff @(posedge iwClk) begin
    if (!iwnRst) begin
      count    <= '0;
      phaseReg <= 1'b1;
    end else if (iwClear) begin
      count <= '0;
    end else if (iwPeriod == '0) begin
      count    <= '0;
      phaseReg <= 1'b1;
    end else if (count == iwPeriod - pPeriodWidth'(1)) begin
      count    <= '0;
      phaseReg <= ~phaseReg;
    end else begin
      count <= count + pPeriodWidth'(1);
    end
  end

  // A zero period forces phase high from the cycle PERIOD becomes zero.
  always_comb begin
    owPhase = phaseReg | (iwPeriod == '0);
  end

endmodule

// File: rtl/mmio_gpio_out.sv
// Memory-mapped output peripheral: per-channel DATA, blink MODE, PERIOD and STATUS registers.
module mmio_gpio_out
  import mmio_gpio_out_pkg::*;
#(
  parameter logic [31:0]             pBaseAddr      = 32'h0000_1000,
  parameter int unsigned             pChannels      = 1,
  parameter int unsigned             pOutWidth      = 8,
  parameter int unsigned             pPeriodWidth   = 24,
  parameter logic [pPeriodWidth-1:0] pDefaultPeriod = 24'd12_500_000
) (
  input  logic                           iwClk,
  input  logic                           iwnRst,
  input  logic [31:0]                    iwReadAddr,
  input  logic [31:0]                    iwWriteAddr,
  input  logic [31:0]                    iwWriteData,
  input  logic [3:0]                     iwWstrb,
  output logic [31:0]                    owReadData,
  output logic                           owReadHit,
  output logic [pChannels*pOutWidth-1:0] owOut
);

  localparam int unsigned WinLsb = $clog2(WINDOW_BYTES);

  logic [pOutWidth-1:0]    dataReg [pChannels];
  logic [pChannels-1:0]    modeReg;
  logic [pPeriodWidth-1:0] periodReg;
  logic                    phase;

  logic        wrEn;
  logic        periodWrite;
  regSel_t     wrSel;
  regSel_t     rdSel;
  logic [2:0]  wrIdx;
  logic [2:0]  rdIdx;
  logic        rdInWin;
  logic [31:0] rdWord;

  // Decode both bus sides against the window.
  always_comb begin
    wrEn        = (iwWriteAddr[31:WinLsb] == pBaseAddr[31:WinLsb]) && (iwWstrb != '0);
    wrSel       = decodeOffset(iwWriteAddr[5:0], pChannels);
    wrIdx       = dataIndex(iwWriteAddr[5:0]);
    periodWrite = wrEn && (wrSel == RegPeriod);
    rdInWin     = (iwReadAddr[31:WinLsb] == pBaseAddr[31:WinLsb]);
    rdSel       = decodeOffset(iwReadAddr[5:0], pChannels);
    rdIdx       = dataIndex(iwReadAddr[5:0]);
  end

  // Register file writes; strobed bytes above each register's width fall away in the truncation.
  always_ff @(posedge iwClk) begin
    if (!iwnRst) begin
      for (int unsigned n = 0; n < pChannels; n++) dataReg[n] <= '0;
      modeReg   <= '0;
      periodReg <= pDefaultPeriod;
    end else if (wrEn) begin
      for (int unsigned n = 0; n < pChannels; n++) begin
        if (wrSel == RegData && 32'(wrIdx) == n)
          dataReg[n] <= pOutWidth'(mergeBytes(32'(dataReg[n]), iwWriteData, iwWstrb));
      end
      if (wrSel == RegMode)
        modeReg <= pChannels'(mergeBytes(32'(modeReg), iwWriteData, iwWstrb));
      if (wrSel == RegPeriod)
        periodReg <= pPeriodWidth'(mergeBytes(32'(periodReg), iwWriteData, iwWstrb));
    end
  end

  blink_timer #(
    .pPeriodWidth(pPeriodWidth)
  ) uTimer (
    .iwClk   (iwClk),
    .iwnRst  (iwnRst),
    .iwPeriod(periodReg),
    .iwClear (periodWrite),
    .owPhase (phase)
  );

  // Read mux over the pre-write register state.
  always_comb begin
    rdWord = '0;
    case (rdSel)
      RegData: begin
        for (int unsigned n = 0; n < pChannels; n++) begin
          if (32'(rdIdx) == n) rdWord = 32'(dataReg[n]);
        end
      end
      RegMode:   rdWord = 32'(modeReg);
      RegPeriod: rdWord = 32'(periodReg);
      RegStatus: rdWord = {31'b0, phase};
      default:   rdWord = '0;
    endcase
  end

  // Registered read response with hit flag.
  always_ff @(posedge iwClk) begin
    if (!iwnRst) begin
      owReadData <= '0;
      owReadHit  <= 1'b0;
    end else begin
      owReadHit  <= rdInWin;
      owReadData <= rdInWin ? rdWord : '0;
    end
  end

  // Channel outputs: blink-mode channels are blanked while phase is low.
  always_comb begin
    owOut = '0;
    for (int unsigned n = 0; n < pChannels; n++) begin
      owOut[n*pOutWidth +: pOutWidth] = (modeReg[n] && !phase) ? '0 : dataReg[n];
    end
  end

endmodule

// File: tb/tb_mmio_gpio_out.sv
// Bench for mmio_gpio_out: reference model for the default configuration plus a 4x4 instance.
module tb_mmio_gpio_out;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam logic [23:0] DEFP = 24'd12_500_000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        nRst;
  logic [31:0] rAddr, wAddr, wData, rData;
  logic [3:0]  wStrb;
  logic        rHit;
  logic [7:0]  out;

  logic        nRst2;
  logic [31:0] rAddr2, wAddr2, wData2, rData2;
  logic [3:0]  wStrb2;
  logic        rHit2;
  logic [15:0] out2;

  mmio_gpio_out dut (
    .iwClk(clk), .iwnRst(nRst), .iwReadAddr(rAddr), .iwWriteAddr(wAddr),
    .iwWriteData(wData), .iwWstrb(wStrb), .owReadData(rData), .owReadHit(rHit), .owOut(out)
  );

  mmio_gpio_out #(
    .pChannels(4),
    .pOutWidth(4)
  ) dut2 (
    .iwClk(clk), .iwnRst(nRst2), .iwReadAddr(rAddr2), .iwWriteAddr(wAddr2),
    .iwWriteData(wData2), .iwWstrb(wStrb2), .owReadData(rData2), .owReadHit(rHit2), .owOut(out2)
  );

  int checks = 0;
  int errors = 0;

  // Reference state for the default instance.
  logic [7:0]  mData;
  logic        mMode;
  logic [23:0] mPeriod;
  int unsigned mCnt;
  logic        mPhase;
  logic [31:0] eRd;
  logic        eHit;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic effPh();
    return (mPeriod == 24'd0) || mPhase;
  endfunction

  function automatic logic [31:0] modelRead(input logic [31:0] a);
    if (a[31:6] != BASE[31:6]) return 32'd0;
    case (a[5:2])
      4'd0:    return {24'd0, mData};
      4'd8:    return {31'd0, mMode};
      4'd9:    return {8'd0, mPeriod};
      4'd10:   return {31'd0, effPh()};
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic rst, input logic [31:0] wa, input logic [31:0] wd,
                      input logic [3:0] ws, input logic [31:0] ra);
    logic        wr;
    logic [31:0] t;
    nRst = rst; wAddr = wa; wData = wd; wStrb = ws; rAddr = ra;
    @(posedge clk);
    if (!rst) begin
      mData = '0; mMode = 1'b0; mPeriod = DEFP; mCnt = 0; mPhase = 1'b1;
      eRd = '0; eHit = 1'b0;
    end else begin
      eHit = (ra[31:6] == BASE[31:6]);
      eRd  = modelRead(ra);
      wr   = (wa[31:6] == BASE[31:6]) && (ws != 4'd0);
      if (wr && wa[5:2] == 4'd9) mCnt = 0;
      else if (mPeriod == 24'd0) begin
        mCnt = 0; mPhase = 1'b1;
      end else begin
        mCnt = (mCnt + 1) % 32'(mPeriod);
        if (mCnt == 0) mPhase = !mPhase;
      end
      if (wr) begin
        case (wa[5:2])
          4'd0: begin t = merge({24'd0, mData}, wd, ws); mData = t[7:0]; end
          4'd8: begin t = merge({31'd0, mMode}, wd, ws); mMode = t[0]; end
          4'd9: begin t = merge({8'd0, mPeriod}, wd, ws); mPeriod = t[23:0]; end
          default: ;
        endcase
      end
    end
    #1;
    chk("out", 32'(out), 32'((mMode && !effPh()) ? 8'd0 : mData));
    chk("rdata", rData, eRd);
    chk("rhit", 32'(rHit), 32'(eHit));
  endtask

  task automatic idle(input logic [31:0] ra);
    step(1'b1, 32'h0, 32'h0, 4'h0, ra);
  endtask

  task automatic step2(input logic rst, input logic [31:0] wa, input logic [31:0] wd,
                       input logic [3:0] ws, input logic [31:0] ra);
    nRst2 = rst; wAddr2 = wa; wData2 = wd; wStrb2 = ws; rAddr2 = ra;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] wa, wd;
    logic [3:0]  ws;
    nRst2 = 1'b0; wAddr2 = '0; wData2 = '0; wStrb2 = '0; rAddr2 = '0;

    // Reset state
    step(1'b0, 32'h0, 32'h0, 4'h0, 32'h0);
    step(1'b0, 32'h0, 32'h0, 4'h0, 32'h0);
    chk("rst_out", 32'(out), 32'h0);

    // Byte write then read-back one edge later (same-cycle read sees old value)
    step(1'b1, BASE, 32'h0000_00A5, 4'b0001, BASE);
    chk("wr_out", 32'(out), 32'hA5);
    idle(BASE);
    chk("rd_a5", rData, 32'hA5);
    chk("rd_a5_hit", 32'(rHit), 32'h1);
    idle(BASE + 32'h24);
    chk("rd_defp", rData, 32'(DEFP));

    // Blink with half-period 3, watching STATUS
    step(1'b1, BASE + 32'h24, 32'd3, 4'hF, BASE + 32'h28);
    step(1'b1, BASE + 32'h20, 32'd1, 4'hF, BASE + 32'h28);
    for (int i = 0; i < 14; i++) idle(BASE + 32'h28);

    // PERIOD = 0 while blanked forces steady output
    for (int i = 0; i < 8 && effPh(); i++) idle(BASE + 32'h28);
    chk("in_phase0", 32'(effPh()), 32'h0);
    step(1'b1, BASE + 32'h24, 32'd0, 4'hF, BASE + 32'h28);
    idle(BASE + 32'h28);
    chk("p0_out", 32'(out), 32'hA5);
    chk("p0_status", rData, 32'h1);

    // Out-of-window read and STATUS write
    idle(BASE + 32'h40);
    chk("oow_hit", 32'(rHit), 32'h0);
    step(1'b1, BASE + 32'h28, 32'hFFFF_FFFF, 4'hF, BASE + 32'h28);
    step(1'b1, BASE + 32'h44, 32'hFFFF_FFFF, 4'hF, BASE);
    step(1'b1, BASE + 32'h04, 32'hFFFF_FFFF, 4'hF, BASE + 32'h04);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 4) == 0) wa = $urandom;
      else wa = BASE + 32'($urandom_range(0, 63));
      wd = $urandom;
      ws = 4'($urandom_range(0, 15));
      if (wa[5:2] == 4'd9) wd = 32'($urandom_range(0, 6));
      if (wa[5:2] == 4'd8) ws[0] = 1'b1;
      step(($urandom_range(0, 99) != 0), wa, wd, ws,
           ($urandom_range(0, 4) == 0) ? 32'($urandom) : BASE + 32'($urandom_range(0, 63)));
    end

    // Reset mid-blink, with a write and read in flight
    step(1'b1, BASE, 32'h0000_005A, 4'hF, BASE);
    step(1'b1, BASE + 32'h24, 32'd2, 4'hF, BASE);
    step(1'b1, BASE + 32'h20, 32'd1, 4'hF, BASE);
    for (int i = 0; i < 5; i++) idle(BASE + 32'h28);
    step(1'b0, BASE, 32'hFF, 4'hF, BASE);
    chk("rst_mid_out", 32'(out), 32'h0);
    chk("rst_mid_hit", 32'(rHit), 32'h0);
    step(1'b1, 32'h0, 32'h0, 4'h0, BASE + 32'h24);
    chk("rst_mid_period", rData, 32'(DEFP));

    // 4-channel, 4-bit instance
    step2(1'b0, 32'h0, 32'h0, 4'h0, 32'h0);
    step2(1'b1, BASE, 32'h3, 4'hF, 32'h0);
    step2(1'b1, BASE + 32'h08, 32'hFFFF_FFFF, 4'hF, 32'h0);
    chk("c4_out", 32'(out2), 32'h0F03);
    step2(1'b1, 32'h0, 32'h0, 4'h0, BASE + 32'h1C);
    chk("c4_rd1c", rData2, 32'h0);
    chk("c4_rd1c_hit", 32'(rHit2), 32'h1);
    step2(1'b1, 32'h0, 32'h0, 4'h0, BASE + 32'h08);
    chk("c4_rd08", rData2, 32'hF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
